udp_panel_stream_writer: RTL and testbench

UDP_PANEL_STREAM_WRITER -- requirements
Module: udp_panel_stream_writer

---
 rtl/udp_panel_stream_writer.sv | 211 +++++++++++++++++++++
 tb/tb_udp_panel_stream_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_panel_stream_writer.sv
// udp_panel_stream_writer
// Parses a byte stream of UDP payloads (panel index, row, start column,
// then packed pixels) and issues one registered pixel write per complete pixel.
// Optional feature: define UDP_PANEL_STATS_EN to add good/drop packet counters.
//
// Ports:
//   clock, reset           sole clock, synchronous active-high reset
//   udp0_source_*          byte stream in (valid/last/data/error), ready out
//   ctrl_en                panel write strobe (one-hot or broadcast all-ones)
//   ctrl_wr                byte-lane strobe, 4'b0111 on a write
//   ctrl_addr              {y, x} pixel address, zero-extended to 16 bits
//   ctrl_wdat              RGB888 pixel (RGB565 input is expanded)
//   led_reg                toggles once per completed good packet
//   good_pkt_count         (UDP_PANEL_STATS_EN) good packets, wraps
//   drop_pkt_count         (UDP_PANEL_STATS_EN) packets sent to DRAIN, wraps
module udp_panel_stream_writer #(
    parameter int unsigned NUM_PANELS      = 8,
    parameter int unsigned X_BITS          = 6,
    parameter int unsigned Y_BITS          = 6,
    parameter int unsigned BYTES_PER_PIXEL = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  udp0_source_valid,
    input  logic                  udp0_source_last,
    input  logic [7:0]            udp0_source_data,
    input  logic                  udp0_source_error,
    output logic                  udp0_source_ready,
    output logic [NUM_PANELS-1:0] ctrl_en,
    output logic [3:0]            ctrl_wr,
    output logic [15:0]           ctrl_addr,
    output logic [23:0]           ctrl_wdat,
    output logic                  led_reg
`ifdef UDP_PANEL_STATS_EN
    ,
    output logic [15:0]           good_pkt_count,
    output logic [15:0]           drop_pkt_count
`endif
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);

    typedef enum logic [2:0] {IDLE, HDR_Y, HDR_X, DATA, DRAIN} state_e;

    state_e                state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic [NUM_PANELS-1:0] en_q, en_d;
    logic [NUM_PANELS-1:0] mask_q, mask_d;
    logic [3:0]            wr_q, wr_d;
    logic [15:0]           addr_q, addr_d;
    logic [23:0]           wdat_q, wdat_d;
    logic                  led_q, led_d;
    logic [X_BITS-1:0]     x_q, x_d;
    logic [Y_BITS-1:0]     y_q, y_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [15:0]           pix_q, pix_d;
    logic                  good_inc, drop_inc;

    logic                  accept;
    logic [23:0]           pix_full;
    logic [23:0]           pix_rgb;

    assign accept   = udp0_source_valid && rdy_q;
    assign pix_full = {pix_q, udp0_source_data};
    // RGB565 is widened by replicating each channel's MSBs into the new LSBs
    assign pix_rgb  = (BYTES_PER_PIXEL == 2)
                    ? {pix_full[15:11], pix_full[15:13],
                       pix_full[10:5],  pix_full[10:9],
                       pix_full[4:0],   pix_full[4:2]}
                    : pix_full;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            en_q    <= '0;
            mask_q  <= '0;
            wr_q    <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            led_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            en_q    <= en_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            led_q   <= led_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
        end
    end

    // Packet parser: next state, pixel assembly and write strobes
    always_comb begin
        state_d  = state_q;
        rdy_d    = 1'b1;
        en_d     = '0;
        wr_d     = '0;
        mask_d   = mask_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        led_d    = led_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        pix_d    = pix_q;
        good_inc = 1'b0;
        drop_inc = 1'b0;

        if (accept) begin
            if (udp0_source_error) begin
                // Bad byte and any partial pixel are dropped; error+last ends the packet here
                cnt_d    = '0;
                state_d  = udp0_source_last ? IDLE : DRAIN;
                drop_inc = !udp0_source_last && (state_q != DRAIN);
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (udp0_source_last) begin
                            state_d = IDLE;
                        end else if (udp0_source_data == 8'hFF) begin
                            mask_d  = '1;
                            state_d = HDR_Y;
                        end else if (32'(udp0_source_data) < NUM_PANELS) begin
                            mask_d  = NUM_PANELS'(1) << udp0_source_data;
                            state_d = HDR_Y;
                        end else begin
                            state_d  = DRAIN;
                            drop_inc = 1'b1;
                        end
                    end
                    HDR_Y: begin
                        y_d     = Y_BITS'(udp0_source_data);
                        state_d = udp0_source_last ? IDLE : HDR_X;
                    end
                    HDR_X: begin
                        x_d     = X_BITS'(udp0_source_data);
                        cnt_d   = '0;
                        state_d = udp0_source_last ? IDLE : DATA;
                    end
                    DATA: begin
                        if (cnt_q == LAST_BYTE) begin
                            en_d   = mask_q;
                            wr_d   = 4'b0111;
                            addr_d = 16'({y_q, x_q});
                            wdat_d = pix_rgb;
                            x_d    = x_q + X_BITS'(1);
                            cnt_d  = '0;
                        end else begin
                            pix_d = {pix_q[7:0], udp0_source_data};
                            cnt_d = cnt_q + 2'd1;
                        end
                        if (udp0_source_last) begin
                            // Trailing partial pixel is simply forgotten
                            state_d  = IDLE;
                            cnt_d    = '0;
                            led_d    = !led_q;
                            good_inc = 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (udp0_source_last) begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign udp0_source_ready = rdy_q;
    assign ctrl_en           = en_q;
    assign ctrl_wr           = wr_q;
    assign ctrl_addr         = addr_q;
    assign ctrl_wdat         = wdat_q;
    assign led_reg           = led_q;

`ifdef UDP_PANEL_STATS_EN
    logic [15:0] good_q;
    logic [15:0] drop_q;

    // Packet statistics, wrapping naturally at 16 bits
    always_ff @(posedge clock) begin
        if (reset) begin
            good_q <= '0;
            drop_q <= '0;
        end else begin
            if (good_inc) good_q <= good_q + 16'd1;
            if (drop_inc) drop_q <= drop_q + 16'd1;
        end
    end

    assign good_pkt_count = good_q;
    assign drop_pkt_count = drop_q;
`else
    logic unused_stats;
    assign unused_stats = good_inc ^ drop_inc;
`endif

endmodule

// File: tb/tb_udp_panel_stream_writer.sv
// Bench for udp_panel_stream_writer: one RGB888 and one RGB565 instance share
// a byte stream; a packet-level model predicts every write and LED toggle.
module tb_udp_panel_stream_writer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic       last  = 1'b0;
    logic       err   = 1'b0;
    logic [7:0] data  = 8'h00;

    logic        rdy_a, rdy_b, led_a, led_b;
    logic [7:0]  en_a, en_b;
    logic [3:0]  wr_a, wr_b;
    logic [15:0] addr_a, addr_b;
    logic [23:0] wdat_a, wdat_b;
`ifdef UDP_PANEL_STATS_EN
    logic [15:0] good_a, drop_a, good_b, drop_b;
`endif

    always #5 clock = ~clock;

    udp_panel_stream_writer #(.NUM_PANELS(8), .X_BITS(6), .Y_BITS(6), .BYTES_PER_PIXEL(3)) dut_a (
        .clock(clock), .reset(reset),
        .udp0_source_valid(valid), .udp0_source_last(last),
        .udp0_source_data(data), .udp0_source_error(err),
        .udp0_source_ready(rdy_a),
        .ctrl_en(en_a), .ctrl_wr(wr_a), .ctrl_addr(addr_a), .ctrl_wdat(wdat_a),
        .led_reg(led_a)
`ifdef UDP_PANEL_STATS_EN
        , .good_pkt_count(good_a), .drop_pkt_count(drop_a)
`endif
    );

    udp_panel_stream_writer #(.NUM_PANELS(8), .X_BITS(6), .Y_BITS(6), .BYTES_PER_PIXEL(2)) dut_b (
        .clock(clock), .reset(reset),
        .udp0_source_valid(valid), .udp0_source_last(last),
        .udp0_source_data(data), .udp0_source_error(err),
        .udp0_source_ready(rdy_b),
        .ctrl_en(en_b), .ctrl_wr(wr_b), .ctrl_addr(addr_b), .ctrl_wdat(wdat_b),
        .led_reg(led_b)
`ifdef UDP_PANEL_STATS_EN
        , .good_pkt_count(good_b), .drop_pkt_count(drop_b)
`endif
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  en;
        logic [15:0] addr;
        logic [23:0] wdat;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  led_par = 0;
    int  exp_good = 0;
    int  exp_drop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rgb565_to_888(input int p16);
        int r, g, b;
        r = (p16 >> 11) & 31;
        g = (p16 >> 5) & 63;
        b = p16 & 31;
        return 24'(((r * 8 + r / 4) << 16) | ((g * 4 + g / 16) << 8) | (b * 8 + b / 4));
    endfunction

    // Packet-level prediction: e = index of errored byte (-1 none), term = ends with last
    task automatic model(input bq_t b, input int e, input bit term);
        int  n, lim, y, x, bpp, p;
        bit  ok_idx;
        logic [7:0] mask;
        wr_t w;
        n = b.size();
        if (n == 0) return;
        lim    = (e >= 0) ? e : n;
        ok_idx = (b[0] == 8'hFF) || (b[0] < 8);
        mask   = (b[0] == 8'hFF) ? 8'hFF : 8'(1 << b[0]);
        if (e >= 0 && (e == 0 || ok_idx)) begin
            if (!(term && e == n - 1)) exp_drop++;
        end else if (!ok_idx) begin
            if (!(term && n == 1)) exp_drop++;
        end
        if (ok_idx && n > 3) begin
            y = b[1];
            x = b[2];
            for (int s = 0; s < 2; s++) begin
                bpp = (s == 0) ? 3 : 2;
                for (int k = 0; 3 + k * bpp + bpp - 1 < lim; k++) begin
                    p      = 3 + k * bpp;
                    w.en   = mask;
                    w.addr = 16'((y % 64) * 64 + (x + k) % 64);
                    if (bpp == 3) begin
                        w.wdat = {b[p], b[p+1], b[p+2]};
                        q_a.push_back(w);
                    end else begin
                        w.wdat = rgb565_to_888(int'(b[p]) * 256 + int'(b[p+1]));
                        q_b.push_back(w);
                    end
                end
            end
        end
        if (term && e < 0 && ok_idx && n >= 4) begin
            led_par ^= 1;
            exp_good++;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l, input bit er);
        int t;
        @(negedge clock);
        if ($urandom_range(0, 3) == 0) begin
            valid = 1'b0;
            @(negedge clock);
        end
        valid = 1'b1;
        data  = d;
        last  = l;
        err   = er;
        t = 0;
        while (!(rdy_a && rdy_b)) begin
            @(negedge clock);
            t++;
            if (t > 20) begin
                check("ready_timeout", 32'(0), 32'(1));
                break;
            end
        end
        @(posedge clock);
    endtask

    task automatic check_pkt_end();
        repeat (2) @(negedge clock);
        check("led_a", 32'(led_a), 32'(led_par));
        check("led_b", 32'(led_b), 32'(led_par));
`ifdef UDP_PANEL_STATS_EN
        check("good_a", 32'(good_a), 32'(exp_good & 16'hFFFF));
        check("drop_a", 32'(drop_a), 32'(exp_drop & 16'hFFFF));
        check("drop_b", 32'(drop_b), 32'(exp_drop & 16'hFFFF));
`endif
    endtask

    task automatic send(input bq_t b, input int e, input bit term);
        model(b, e, term);
        for (int i = 0; i < b.size(); i++)
            send_byte(b[i], term && (i == b.size() - 1), i == e);
        @(negedge clock);
        valid = 1'b0;
        last  = 1'b0;
        err   = 1'b0;
        if (term) check_pkt_end();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        valid = 1'b0;
        last  = 1'b0;
        err   = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(rdy_a), 32'(0));
        check("rst_en", 32'(en_a | en_b), 32'(0));
        check("rst_wr", 32'(wr_a), 32'(0));
        check("rst_addr", 32'(addr_a), 32'(0));
        check("rst_wdat", 32'(wdat_a), 32'(0));
        check("rst_led", 32'(led_a | led_b), 32'(0));
        check("rst_pending_a", 32'(q_a.size()), 32'(0));
        check("rst_pending_b", 32'(q_b.size()), 32'(0));
        q_a.delete();
        q_b.delete();
        led_par  = 0;
        exp_good = 0;
        exp_drop = 0;
        reset = 1'b0;
        #1 check("ready_after_rst", 32'(rdy_a), 32'(0));
        @(negedge clock);
        check("ready_up", 32'(rdy_a && rdy_b), 32'(1));
    endtask

    // Write monitor: every strobe must match the next predicted write
    always @(negedge clock) begin
        wr_t w;
        if (en_a != 8'h00) begin
            if (q_a.size() == 0) check("a_spurious_wr", 32'(en_a), 32'(0));
            else begin
                w = q_a.pop_front();
                check("a_en", 32'(en_a), 32'(w.en));
                check("a_wr", 32'(wr_a), 32'(4'b0111));
                check("a_addr", 32'(addr_a), 32'(w.addr));
                check("a_wdat", 32'(wdat_a), 32'(w.wdat));
            end
        end else check("a_wr_idle", 32'(wr_a), 32'(0));
        if (en_b != 8'h00) begin
            if (q_b.size() == 0) check("b_spurious_wr", 32'(en_b), 32'(0));
            else begin
                w = q_b.pop_front();
                check("b_en", 32'(en_b), 32'(w.en));
                check("b_wr", 32'(wr_b), 32'(4'b0111));
                check("b_addr", 32'(addr_b), 32'(w.addr));
                check("b_wdat", 32'(wdat_b), 32'(w.wdat));
            end
        end else check("b_wr_idle", 32'(wr_b), 32'(0));
    end

    initial begin
        bq_t p;
        int  n, sel, e;
        do_reset();

        // Column wrap across a packet, panel 2
        p = '{8'h02, 8'h05, 8'h3F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
        send(p, -1, 1'b1);
        // Broadcast
        p = '{8'hFF, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        send(p, -1, 1'b1);
        // RGB565 magenta (a partial pixel on the RGB888 instance)
        p = '{8'h00, 8'h00, 8'h00, 8'hF8, 8'h1F};
        send(p, -1, 1'b1);
        // Error on the second pixel's first byte
        p = '{8'h01, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send(p, 6, 1'b1);
        // Out-of-range panel index, then a truncated header
        p = '{8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send(p, -1, 1'b1);
        p = '{8'h04, 8'h01};
        send(p, -1, 1'b1);
        // Error together with last
        p = '{8'h03, 8'h02, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40};
        send(p, 6, 1'b1);

        for (int i = 0; i < 150; i++) begin
            p.delete();
            n   = $urandom_range(1, 14);
            sel = $urandom_range(0, 19);
            if (sel < 14)      p.push_back(8'($urandom_range(0, 7)));
            else if (sel < 17) p.push_back(8'hFF);
            else               p.push_back(8'($urandom_range(8, 254)));
            for (int j = 1; j < n; j++) p.push_back(8'($urandom));
            e = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            send(p, e, 1'b1);
        end

        // Reset in the middle of pixel data abandons the packet
        p = '{8'h03, 8'h07, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send(p, -1, 1'b0);
        repeat (2) @(negedge clock);
        do_reset();
        p = '{8'h05, 8'h09, 8'h21, 8'hC0, 8'hFF, 8'hEE};
        send(p, -1, 1'b1);

        repeat (5) @(negedge clock);
        check("end_pending_a", 32'(q_a.size()), 32'(0));
        check("end_pending_b", 32'(q_b.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
